// File: rtl/multdiv_pkg.sv
// Shared types and opcode classification helpers for the iterative multiply/divide unit.
package multdiv_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } md_state_e;

   function automatic logic is_div(md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
   endfunction

   function automatic logic is_rem(md_op_e op);
      return (op == MD_REM) || (op == MD_REMU);
   endfunction

   // MUL is treated as signed*signed; its low half is identical either way.
   function automatic logic is_signed_a(md_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic is_signed_b(md_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/multdiv_step.sv
// One radix-2 step: shift-add multiply or restoring-divide on a 2*WIDTH accumulator.
module multdiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               div_i,
   input  logic [WIDTH-1:0]   opnd_i,
   input  logic [2*WIDTH-1:0] acc_i,
   output logic [2*WIDTH-1:0] acc_o
);

   logic [WIDTH:0]   add_a;
   logic [WIDTH:0]   add_b;
   logic [WIDTH+1:0] sum;

   // Divide packs {remainder, quotient}; the carry out of the subtract means no borrow.
   always_comb begin
      if (div_i) begin
         add_a = acc_i[2*WIDTH-1:WIDTH-1];
         add_b = ~{1'b0, opnd_i};
      end else begin
         add_a = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
         add_b = acc_i[0] ? {1'b0, opnd_i} : '0;
      end
      sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, div_i};
      if (div_i) begin
         if (sum[WIDTH+1]) begin
            acc_o = {sum[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = {sum[WIDTH:0], acc_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/multdiv_iter_param.sv
// Iterative RISC-V M-extension multiply/divide with valid/ready handshakes and kill.
//
//   state | meaning
//   IDLE  | ready for a request; operands latched on accept
//   CALC  | UNROLL magnitude steps per cycle, down-counter to zero
//   FIX   | sign correction and half/quotient/remainder select
//   DONE  | response valid, held until resp_ready_i
module multdiv_iter_param
   import multdiv_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   input  logic             kill_i,
   output logic             resp_valid_o,
   input  logic             resp_ready_i,
   output logic [WIDTH-1:0] result_o,
   output logic             busy_o
);

   localparam int ITERS = WIDTH / UNROLL;
   localparam int CW    = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam logic [CW-1:0]    CNT_INIT = CW'(ITERS - 1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   md_state_e          state_q, state_d;
   md_op_e             op_q, op_d;
   logic               neg_q, neg_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;

   md_op_e             req_op;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] fix_src, fix_neg;
   logic [WIDTH-1:0]   fix_res;
   logic               div_mode;
   logic [2*WIDTH-1:0] step_acc [UNROLL+1];

   assign req_op   = md_op_e'(op_i);
   assign a_neg    = is_signed_a(req_op) && op_a_i[WIDTH-1];
   assign b_neg    = is_signed_b(req_op) && op_b_i[WIDTH-1];
   assign abs_a    = a_neg ? -op_a_i : op_a_i;
   assign abs_b    = b_neg ? -op_b_i : op_b_i;
   assign div_mode = is_div(op_q);

   assign step_acc[0] = acc_q;
   for (genvar i = 0; i < UNROLL; i++) begin : g_step
      multdiv_step #(.WIDTH(WIDTH)) u_step (
         .div_i  (div_mode),
         .opnd_i (opnd_q),
         .acc_i  (step_acc[i]),
         .acc_o  (step_acc[i+1])
      );
   end

   // One shared negator covers product, quotient and remainder.
   always_comb begin
      if (!div_mode) begin
         fix_src = acc_q;
      end else if (is_rem(op_q)) begin
         fix_src = {{WIDTH{1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
      end else begin
         fix_src = {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
      end
      fix_neg = neg_q ? -fix_src : fix_src;
      if ((op_q == MD_MUL) || div_mode) begin
         fix_res = fix_neg[WIDTH-1:0];
      end else begin
         fix_res = fix_neg[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && !kill_i) begin
               op_d  = req_op;
               neg_d = is_rem(req_op) ? a_neg : (a_neg ^ b_neg);
               cnt_d = CNT_INIT;
               if (is_div(req_op)) begin
                  acc_d  = {{WIDTH{1'b0}}, abs_a};
                  opnd_d = abs_b;
               end else begin
                  acc_d  = {{WIDTH{1'b0}}, abs_b};
                  opnd_d = abs_a;
               end
               if (is_div(req_op) && (op_b_i == '0)) begin
                  result_d = is_rem(req_op) ? op_a_i : '1;
                  state_d  = ST_DONE;
               end else if (is_div(req_op) && is_signed_a(req_op) &&
                            (op_a_i == MIN_VAL) && (op_b_i == '1)) begin
                  result_d = is_rem(req_op) ? '0 : MIN_VAL;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            if (kill_i) begin
               state_d = ST_IDLE;
            end else begin
               acc_d = step_acc[UNROLL];
               if (cnt_q == '0) begin
                  state_d = ST_FIX;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
         end
         ST_FIX: begin
            if (kill_i) begin
               state_d = ST_IDLE;
            end else begin
               result_d = fix_res;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         op_q     <= MD_MUL;
         neg_q    <= 1'b0;
         acc_q    <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign req_ready_o  = (state_q == ST_IDLE);
   assign resp_valid_o = (state_q == ST_DONE);
   assign busy_o       = (state_q != ST_IDLE);
   assign result_o     = result_q;

endmodule

// File: tb/tb_multdiv_iter_param.sv
// Scoreboard bench running UNROLL=1 and UNROLL=4 instances side by side against an arithmetic model.
module tb_multdiv_iter_param;
   import multdiv_pkg::*;

   localparam int W  = 32;
   localparam int NI = 2;

   typedef struct {
      logic [W-1:0] res;
      int           acc_cyc;
      int           lat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic         rst [NI];
   logic         req_valid [NI];
   logic         kill [NI];
   logic         resp_ready [NI];
   logic [2:0]   op [NI];
   logic [W-1:0] a [NI];
   logic [W-1:0] b [NI];
   logic         req_ready [NI];
   logic         resp_valid [NI];
   logic         busy [NI];
   logic [W-1:0] result [NI];

   int n_vec = 0;
   int n_err = 0;

   function automatic void check(string name, int k, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s[u%0d]: got %0h expected %0h", name, k, act, exp);
      end
   endfunction

   function automatic void fail_now(string name, int k);
      n_vec++;
      n_err++;
      $display("FAIL %s[u%0d]: got timeout expected DUT event", name, k);
   endfunction

   function automatic logic [W-1:0] ref_model(md_op_e o, logic [W-1:0] x, logic [W-1:0] y);
      longint          sx, sy;
      longint unsigned ux, uy;
      logic [63:0]     p;
      logic            ovf;
      sx  = longint'(signed'(x));
      sy  = longint'(signed'(y));
      ux  = {32'd0, x};
      uy  = {32'd0, y};
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      p   = '0;
      case (o)
         MD_MUL:    begin p = ux * uy; return p[31:0]; end
         MD_MULH:   begin p = sx * sy; return p[63:32]; end
         MD_MULHSU: begin p = sx * longint'(uy); return p[63:32]; end
         MD_MULHU:  begin p = ux * uy; return p[63:32]; end
         MD_DIV: begin
            if (y == 0) return 32'hFFFF_FFFF;
            if (ovf) return 32'h8000_0000;
            p = sx / sy; return p[31:0];
         end
         MD_DIVU: begin
            if (y == 0) return 32'hFFFF_FFFF;
            p = ux / uy; return p[31:0];
         end
         MD_REM: begin
            if (y == 0) return x;
            if (ovf) return 32'd0;
            p = sx % sy; return p[31:0];
         end
         default: begin
            if (y == 0) return x;
            p = ux % uy; return p[31:0];
         end
      endcase
   endfunction

   function automatic logic is_fast(md_op_e o, logic [W-1:0] x, logic [W-1:0] y);
      if (!(o inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU})) return 1'b0;
      if (y == 0) return 1'b1;
      return (o inside {MD_DIV, MD_REM}) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int UNR = (g == 0) ? 1 : 4;
      localparam int LAT = W / UNR + 2;

      exp_t         q[$];
      exp_t         e;
      int           first_valid;
      logic         prev_valid;
      logic [W-1:0] held;

      multdiv_iter_param #(.WIDTH(W), .UNROLL(UNR)) u_dut (
         .clk_i        (clk),
         .rst_i        (rst[g]),
         .req_valid_i  (req_valid[g]),
         .req_ready_o  (req_ready[g]),
         .op_i         (op[g]),
         .op_a_i       (a[g]),
         .op_b_i       (b[g]),
         .kill_i       (kill[g]),
         .resp_valid_o (resp_valid[g]),
         .resp_ready_i (resp_ready[g]),
         .result_o     (result[g]),
         .busy_o       (busy[g])
      );

      initial begin
         first_valid = 0;
         prev_valid  = 1'b0;
         held        = '0;
      end

      always @(negedge clk) begin
         if (rst[g]) begin
            q.delete();
            prev_valid = 1'b0;
         end else begin
            if (resp_valid[g]) begin
               if (!prev_valid) begin
                  first_valid = cyc;
                  held        = result[g];
                  if (q.size() == 0) check("spurious_valid", g, 64'(resp_valid[g]), 64'd0);
               end else begin
                  check("result_stable", g, 64'(result[g]), 64'(held));
               end
               if (resp_ready[g] && q.size() > 0) begin
                  e = q.pop_front();
                  check("result", g, 64'(result[g]), 64'(e.res));
                  check("latency", g, 64'(first_valid - e.acc_cyc), 64'(e.lat));
               end
            end
            prev_valid = resp_valid[g];
            if (req_valid[g] && req_ready[g] && !kill[g]) begin
               e.res     = ref_model(md_op_e'(op[g]), a[g], b[g]);
               e.acc_cyc = cyc;
               e.lat     = is_fast(md_op_e'(op[g]), a[g], b[g]) ? 1 : LAT;
               q.push_back(e);
            end
            if (kill[g] && busy[g] && !resp_valid[g] && q.size() > 0) begin
               void'(q.pop_back());
            end
         end
      end
   end

   task automatic step(int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [W-1:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom());
      endcase
   endfunction

   task automatic issue(int k, md_op_e o, logic [W-1:0] av, logic [W-1:0] bv);
      bit ok;
      ok           = 1'b0;
      op[k]        = o;
      a[k]         = av;
      b[k]         = bv;
      req_valid[k] = 1'b1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (req_ready[k]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("req_timeout", k);
      step(1);
      req_valid[k] = 1'b0;
      op[k]        = 3'($urandom_range(0, 7));
      a[k]         = 32'($urandom());
      b[k]         = 32'($urandom());
   endtask

   task automatic wait_valid(int k, output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (resp_valid[k]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_now("resp_timeout", k);
   endtask

   task automatic take_resp(int k, int hold);
      bit ok;
      wait_valid(k, ok);
      step(1);
      if (ok) begin
         step(hold);
         resp_ready[k] = 1'b1;
         step(1);
         resp_ready[k] = 1'b0;
      end
   endtask

   md_op_e       d_op [12] = '{MD_MUL, MD_MULH, MD_MULHU, MD_MULHSU, MD_DIV, MD_REM,
                               MD_DIV, MD_REM, MD_DIV, MD_REM, MD_DIVU, MD_DIVU};
   logic [W-1:0] d_a  [12] = '{32'd7, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100,
                               32'd100, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                               32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd9};
   logic [W-1:0] d_b  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h8000_0000, 32'd2, 32'd0,
                               32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd3, 32'd3};

   task automatic run(int k);
      bit     ok;
      bit     seen;
      int     iters;
      int     kc;
      md_op_e o;
      iters = (k == 0) ? W : W / 4;
      kc    = (iters > 10) ? 10 : iters - 2;

      step(2);
      rst[k] = 1'b0;
      @(negedge clk);
      check("rst_req_ready", k, 64'(req_ready[k]), 64'd1);
      check("rst_resp_valid", k, 64'(resp_valid[k]), 64'd0);
      check("rst_busy", k, 64'(busy[k]), 64'd0);
      check("rst_result", k, 64'(result[k]), 64'd0);
      step(1);

      for (int i = 0; i < 12; i++) begin
         issue(k, d_op[i], d_a[i], d_b[i]);
         take_resp(k, i % 3);
      end

      // backpressure with a competing request held on the input
      issue(k, MD_DIVU, 32'd1000, 32'd7);
      wait_valid(k, ok);
      step(1);
      op[k]        = 3'(MD_MUL);
      a[k]         = 32'd12345;
      b[k]         = 32'hFFFF_0001;
      req_valid[k] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_req_ready", k, 64'(req_ready[k]), 64'd0);
         check("bp_resp_valid", k, 64'(resp_valid[k]), 64'd1);
      end
      step(1);
      resp_ready[k] = 1'b1;
      step(1);
      resp_ready[k] = 1'b0;
      @(negedge clk);
      check("idle_after_resp", k, 64'(req_ready[k]), 64'd1);
      check("idle_no_valid", k, 64'(resp_valid[k]), 64'd0);
      step(1);
      req_valid[k] = 1'b0;
      @(negedge clk);
      check("second_accepted", k, 64'(busy[k]), 64'd1);
      take_resp(k, 0);

      // kill in IDLE blocks acceptance
      op[k]        = 3'(MD_MUL);
      a[k]         = 32'd3;
      b[k]         = 32'd5;
      req_valid[k] = 1'b1;
      kill[k]      = 1'b1;
      step(2);
      req_valid[k] = 1'b0;
      kill[k]      = 1'b0;
      @(negedge clk);
      check("kill_idle_busy", k, 64'(busy[k]), 64'd0);
      step(1);

      // kill mid-CALC
      issue(k, MD_DIVU, 32'hDEAD_BEEF, 32'd17);
      step(kc - 1);
      kill[k] = 1'b1;
      step(1);
      kill[k] = 1'b0;
      @(negedge clk);
      check("kill_busy", k, 64'(busy[k]), 64'd0);
      check("kill_req_ready", k, 64'(req_ready[k]), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (resp_valid[k]) seen = 1'b1;
      end
      check("kill_no_resp", k, 64'(seen), 64'd0);
      step(1);
      issue(k, MD_DIVU, 32'd9, 32'd3);
      take_resp(k, 0);

      // reset while DONE
      issue(k, MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_valid(k, ok);
      step(1);
      rst[k] = 1'b1;
      step(1);
      rst[k] = 1'b0;
      @(negedge clk);
      check("rst_done_valid", k, 64'(resp_valid[k]), 64'd0);
      check("rst_done_result", k, 64'(result[k]), 64'd0);
      check("rst_done_ready", k, 64'(req_ready[k]), 64'd1);
      step(1);

      for (int i = 0; i < 40; i++) begin
         o = md_op_e'($urandom_range(0, 7));
         issue(k, o, rand_opnd(), rand_opnd());
         take_resp(k, $urandom_range(0, 3));
      end
      step(3);
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst[k]        = 1'b1;
         req_valid[k]  = 1'b0;
         kill[k]       = 1'b0;
         resp_ready[k] = 1'b0;
         op[k]         = '0;
         a[k]          = '0;
         b[k]          = '0;
      end
      fork
         run(0);
         run(1);
      join
      check("drained", 0, 64'(g_inst[0].q.size()), 64'd0);
      check("drained", 1, 64'(g_inst[1].q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no finish expected finish before 60000 cycles");
      $fatal(1);
   end

endmodule
